bcd_timekeeper: RTL
===================

# bcd_timekeeper

Parametrised BCD timekeeper that extends the mm:ss counter with an optional hours stage, up/down counting, preset load, a run/pause/done state machine and a valid/ready snapshot logger. It sits between the 1 Hz tick generator and the display/log memory path. It drives packed BCD time to the 7-segment mux and presents timestamp records with a write address to the log RAM writer.

## Interface
- ADDR_W, 16, log address width
- DEPTH, 1024, number of log entries; log_addr wraps after DEPTH-1 (DEPTH ≤ 2**ADDR_W)
- HOURS, 0, 1 adds an hh stage (00-23)
- DATA_W (localparam), HOURS ? 24 : 16, packed time width, 4 bits per digit, most significant digit first

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- tick  in  1  one-cycle count enable
- start  in  1  enter RUN
- stop  in  1  enter PAUSED
- clear  in  1  zero the time and go to IDLE
- load  in  1  preset the time from load_value
- load_value  in  DATA_W  BCD preset
- dir  in  1  0 = count up, 1 = count down
- snap  in  1  request a timestamp record
- log_ready  in  1  log RAM writer accepts the record
- time_bcd  out  DATA_W  current time
- running  out  1  state == RUN
- expired  out  1  state == DONE
- wrap  out  1  one-cycle pulse on up-count rollover to zero
- log_valid  out  1  record pending
- log_data  out  DATA_W  captured time
- log_addr  out  ADDR_W  address of the pending or next record
- log_drop  out  1  sticky: a snap was lost; cleared only by clear or reset

## Operation
- States: IDLE, RUN, PAUSED, DONE. Encoding is free; running and expired are decoded from the state.
- Control priority per cycle: clear > load > stop > start > tick.
- clear: time goes to 0, state to IDLE, log_drop to 0. log_addr and any pending record are untouched.
- load: time_bcd takes the saturated load_value. State moves to PAUSED from any state, including DONE.
- Saturation rules:
  - A units digit above 9 is loaded as 9.
  - A minute or second tens digit above 5 is loaded as 5.
  - An hour tens digit above 2 is loaded as 2.
  - If the hour tens digit (after clamping) is 2, an hour units digit above 3 is loaded as 3.
- start: IDLE or PAUSED goes to RUN. If dir=1 and the time is zero, the block goes to DONE instead. start is ignored in DONE.
- stop: RUN goes to PAUSED.
- Counting happens only when state==RUN, no higher-priority control is active, and tick=1.
- Up count:
  - Seconds 00-59 carry into minutes 00-59.
  - Minutes carry into hours 00-23 when HOURS=1.
  - Rollover from the maximum (59:59, or 23:59:59) goes to all zero, asserts wrap, and stays in RUN.
- Down count:
  - Decrement with borrow: 00 seconds becomes 59, 00 minutes becomes 59, 00 hours becomes 23.
  - A decrement that produces zero moves RUN to DONE in the same update. The time holds at zero.
- dir is sampled on every counting tick and may change at any time.
- Logger:
  - When snap=1 and log_valid=0, log_data captures time_bcd as it stands in that cycle (pre-update). log_valid rises the next cycle.
  - Entry into DONE generates an automatic snap of the zero time.
  - log_valid, log_data and log_addr hold stable until log_valid & log_ready. In the handshake cycle log_valid drops and log_addr increments modulo DEPTH.
  - A snap (explicit or automatic) while log_valid=1 is dropped and sets log_drop. A snap in the handshake cycle itself is also dropped.

## Timing
- Reset values:
  - time_bcd = 0, log_data = 0, log_addr = 0.
  - running = 0, expired = 0, wrap = 0.
  - log_valid = 0, log_drop = 0.
  - State = IDLE.
- Every output is registered. No combinational input-to-output path.
- Latency:
  - tick to time_bcd update: 1 cycle.
  - start/stop/clear/load to state and time change: 1 cycle.
  - snap to log_valid: 1 cycle.
- start and tick in the same cycle from IDLE or PAUSED: the tick is not counted (the state was not yet RUN).
- stop and tick in the same cycle in RUN: no count.
- wrap is high for exactly the one cycle after the rollover update.
- Reset asserted mid-operation immediately returns every register to its reset value, including dropping a pending log record.

## Test plan
- Up rollover, HOURS=0: load 0x5958, start, 2 ticks -> time_bcd = 0x5959, then 0x0000, wrap pulses 1 cycle, running stays 1.
- Down expiry, HOURS=1: load 0x000002, dir=1, start, 2 ticks -> 0x000001, then 0x000000, expired=1, log_valid=1 with log_data=0x000000; a further tick causes no change; start ignored.
- Saturating load, HOURS=1: load_value 0x3A7F6C -> time_bcd = 0x235959, state PAUSED; load_value 0x27xxxx -> hour units clamped to 3.
- Priority: clear+load+start same cycle in RUN at 0x1234 -> time 0, IDLE, log_drop cleared. start+tick from PAUSED at 0x0010 -> RUN, time 0x0010 unchanged.
- Logger backpressure: snap at 0x0105 with log_ready=0, then snap again -> log_data holds 0x0105, log_drop=1. Raise log_ready -> one handshake, log_addr 0 -> 1.
- Address wrap, DEPTH=4: 4 accepted records -> log_addr returns to 0. Reset asserted while log_valid=1 -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/bcd_timekeeper.sv
// BCD mm:ss (optionally hh:mm:ss) timekeeper with up/down count, saturating preset,
// run/pause/done control and a single-entry valid/ready timestamp logger.
module bcd_timekeeper #(
   parameter int ADDR_W = 16,
   parameter int DEPTH  = 1024,
   parameter int HOURS  = 0,
   localparam int DATA_W = (HOURS != 0) ? 24 : 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick,
   input  logic              start,
   input  logic              stop,
   input  logic              clear,
   input  logic              load,
   input  logic [DATA_W-1:0] load_value,
   input  logic              dir,
   input  logic              snap,
   input  logic              log_ready,
   output logic [DATA_W-1:0] time_bcd,
   output logic              running,
   output logic              expired,
   output logic              wrap,
   output logic              log_valid,
   output logic [DATA_W-1:0] log_data,
   output logic [ADDR_W-1:0] log_addr,
   output logic              log_drop
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_RUN    = 2'd1;
   localparam logic [1:0] S_PAUSED = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   // Time is always held as six digits; the hour digits stay zero when HOURS=0.
   logic [23:0] tm, tm_nxt, cap;
   logic [24:0] up;
   logic [23:0] dn;
   logic [1:0]  state, state_nxt;
   logic        wrap_nxt, auto_snap, snap_req, accept, drop, hs;

   function automatic logic [3:0] digit_lim(input int i);
      return ((i % 2) != 0) ? 4'd5 : 4'd9;
   endfunction

   function automatic logic [23:0] sat_bcd(input logic [23:0] v);
      logic [23:0] r;
      r = v;
      for (int i = 0; i < 4; i++)
         if (r[i*4 +: 4] > digit_lim(i)) r[i*4 +: 4] = digit_lim(i);
      if (HOURS != 0) begin
         if (r[23:20] > 4'd2) r[23:20] = 4'd2;
         if (r[23:20] == 4'd2 && r[19:16] > 4'd3) r[19:16] = 4'd3;
         else if (r[19:16] > 4'd9) r[19:16] = 4'd9;
      end else begin
         r[23:16] = 8'h00;
      end
      return r;
   endfunction

   // Returns {rollover, next_time}; rollover means the count wrapped to all zero.
   function automatic logic [24:0] bcd_up(input logic [23:0] t);
      logic [23:0] r;
      logic        c;
      r = t;
      c = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (c) begin
            if (r[i*4 +: 4] >= digit_lim(i)) r[i*4 +: 4] = 4'd0;
            else begin
               r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      if (HOURS != 0 && c) begin
         if (r[23:16] == 8'h23) r[23:16] = 8'h00;
         else begin
            c = 1'b0;
            if (r[19:16] >= 4'd9) begin
               r[19:16] = 4'd0;
               r[23:20] = r[23:20] + 4'd1;
            end else begin
               r[19:16] = r[19:16] + 4'd1;
            end
         end
      end
      return {c, r};
   endfunction

   function automatic logic [23:0] bcd_dn(input logic [23:0] t);
      logic [23:0] r;
      logic        b;
      r = t;
      b = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (b) begin
            if (r[i*4 +: 4] == 4'd0) r[i*4 +: 4] = digit_lim(i);
            else begin
               r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
               b = 1'b0;
            end
         end
      end
      if (HOURS != 0 && b) begin
         if (r[23:16] == 8'h00) r[23:16] = 8'h23;
         else if (r[19:16] == 4'd0) begin
            r[19:16] = 4'd9;
            r[23:20] = r[23:20] - 4'd1;
         end else begin
            r[19:16] = r[19:16] - 4'd1;
         end
      end
      return r;
   endfunction

   always_comb begin
      state_nxt = state;
      tm_nxt    = tm;
      wrap_nxt  = 1'b0;
      up        = bcd_up(tm);
      dn        = bcd_dn(tm);
      if (clear) begin
         tm_nxt    = 24'h000000;
         state_nxt = S_IDLE;
      end else if (load) begin
         tm_nxt    = sat_bcd(24'(load_value));
         state_nxt = S_PAUSED;
      end else if (stop) begin
         if (state == S_RUN) state_nxt = S_PAUSED;
      end else if (start) begin
         if (state == S_IDLE || state == S_PAUSED)
            state_nxt = (dir && tm == 24'h000000) ? S_DONE : S_RUN;
      end else if (tick && state == S_RUN) begin
         if (dir) begin
            tm_nxt = dn;
            if (dn == 24'h000000) state_nxt = S_DONE;
         end else begin
            tm_nxt   = up[23:0];
            wrap_nxt = up[24];
         end
      end
   end

   // An explicit snap wins the single slot over a simultaneous automatic one;
   // any snap that finds the slot occupied (handshake cycle included) is lost.
   always_comb begin
      auto_snap = (state_nxt == S_DONE) && (state != S_DONE);
      snap_req  = snap | auto_snap;
      hs        = log_valid & log_ready;
      accept    = snap_req & ~log_valid;
      drop      = (snap_req & log_valid) | (~log_valid & snap & auto_snap);
      cap       = snap ? tm : 24'h000000;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         tm        <= 24'h000000;
         running   <= 1'b0;
         expired   <= 1'b0;
         wrap      <= 1'b0;
         log_valid <= 1'b0;
         log_data  <= '0;
         log_addr  <= '0;
         log_drop  <= 1'b0;
      end else begin
         state   <= state_nxt;
         tm      <= tm_nxt;
         running <= (state_nxt == S_RUN);
         expired <= (state_nxt == S_DONE);
         wrap    <= wrap_nxt;
         if (hs) begin
            log_valid <= 1'b0;
            log_addr  <= (log_addr == ADDR_W'(DEPTH - 1)) ? '0 : log_addr + ADDR_W'(1);
         end else if (accept) begin
            log_valid <= 1'b1;
            log_data  <= cap[DATA_W-1:0];
         end
         if (clear)     log_drop <= 1'b0;
         else if (drop) log_drop <= 1'b1;
      end
   end

   assign time_bcd = tm[DATA_W-1:0];

endmodule
